// File: rtl/fir_tap_accumulator.sv
// ---------------------------------------------------------------------------
// fir_tap_accumulator
//
// Sequential multiply-accumulate back end for the FIR datapath. The block
// accepts one signed partial product per handshake beat and adds NTAPS of
// them in a widened accumulator. It then presents one filter output sample
// per group. Valid/ready handshakes on both sides let it stall against the
// output sink.
//
// Parameters
//   DATA_W  width of the signed input partial product
//   ACC_W   accumulator / output width, ACC_W >= DATA_W + clog2(NTAPS)
//   NTAPS   number of terms summed per output sample (>= 2)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous abort of the current group (drops any held result)
//   in_valid   in_data is valid
//   in_ready   block accepts a term this cycle (ACCUM state)
//   in_data    signed partial product, DATA_W bits
//   out_valid  out_data holds a completed sum (HOLD state)
//   out_ready  sink accepts the result
//   out_data   signed result, ACC_W bits
//   out_ovf    result was clamped (only with ACC_SAT_EN)
//
// Configuration macro
//   ACC_SAT_EN  when defined, the result is clamped to the signed DATA_W
//               range and sign-extended to ACC_W, and out_ovf flags the
//               clamp. When undefined, out_data is the raw ACC_W sum and
//               out_ovf is tied low.
// ---------------------------------------------------------------------------
module fir_tap_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 20,
    parameter int NTAPS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTAPS - 1);

    // Parameter sanity: the accumulator must never wrap within one group.
    generate
        if (NTAPS < 2) begin : g_bad_ntaps
            $error("fir_tap_accumulator: NTAPS must be at least 2");
        end
        if (ACC_W < DATA_W + $clog2(NTAPS)) begin : g_bad_accw
            $error("fir_tap_accumulator: ACC_W too narrow for NTAPS terms");
        end
    endgenerate

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;

    logic               accept;
    logic               last_term;
    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   result_data;
    logic               result_ovf;

    // Handshake outputs come straight from the registered state. No input
    // reaches them combinationally.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;

    // A term presented while flush is high is discarded even though
    // in_ready may be 1, so flush gates the accept itself.
    assign accept    = in_valid & in_ready & ~flush;
    assign last_term = (cnt_q == LAST_CNT);

    // The sum is computed modulo 2^ACC_W. ACC_W is sized so a full group
    // cannot wrap.
    assign term_ext = ACC_W'($signed(in_data));
    assign sum      = acc_q + term_ext;

`ifdef ACC_SAT_EN
    // Clamp bounds are the signed DATA_W extremes, held at ACC_W width.
    localparam logic [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic out_ovf_q, out_ovf_d;

    assign out_ovf = out_ovf_q;

    // The final group sum is compared as a signed ACC_W value and clamped
    // into the DATA_W range, recording whether clamping happened.
    always_comb begin
        result_data = sum;
        result_ovf  = 1'b0;
        if ($signed(sum) > $signed(SAT_MAX)) begin
            result_data = SAT_MAX;
            result_ovf  = 1'b1;
        end else if ($signed(sum) < $signed(SAT_MIN)) begin
            result_data = SAT_MIN;
            result_ovf  = 1'b1;
        end
    end
`else
    // Without saturation the raw modular sum is the result and the overflow
    // flag is constantly low.
    assign out_ovf     = 1'b0;
    assign result_data = sum;
    assign result_ovf  = 1'b0;
`endif

    // Next-state and datapath update. Flush outranks everything except
    // reset. It returns to ACCUM and clears the partial group and the
    // overflow flag. out_data keeps its last value because out_valid is
    // what qualifies it.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
`ifdef ACC_SAT_EN
        out_ovf_d  = out_ovf_q;
`endif
        if (flush) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef ACC_SAT_EN
            out_ovf_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (last_term) begin
                            out_data_d = result_data;
`ifdef ACC_SAT_EN
                            out_ovf_d  = result_ovf;
`endif
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = ST_HOLD;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

`ifndef ACC_SAT_EN
    // result_ovf is only consumed by the saturating build.
    logic unused_ovf;
    assign unused_ovf = result_ovf;
`endif

    // State register. Reset clears all outputs at once, without waiting
    // for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef ACC_SAT_EN
    // The overflow flag is registered alongside out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ovf_q <= 1'b0;
        end else begin
            out_ovf_q <= out_ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_accumulator
//
// Scoreboard bench for fir_tap_accumulator. The stimulus side keeps a
// behavioural model: a queue of accepted terms plus a "result pending" flag.
// When a group completes, the model pushes the expected result into a
// scoreboard. A separate monitor compares the result whenever the DUT
// presents out_valid, and pops it when the sink accepts it.
// ---------------------------------------------------------------------------
module tb_fir_tap_accumulator;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 20;
    localparam int NTAPS  = 8;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    fir_tap_accumulator #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .NTAPS (NTAPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    longint           terms[$];
    bit               model_hold = 1'b0;
    logic [ACC_W-1:0] sb_data[$];
    logic             sb_ovf[$];
    logic [ACC_W-1:0] last_data = '0;
    logic             last_ovf = 1'b0;
    bit               mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result for a completed group, derived from the plain
    // integer sum of its terms.
    task automatic modelGroup();
        longint s = 0;
        logic [ACC_W-1:0] d;
        logic o;
        foreach (terms[i]) s += terms[i];
`ifdef ACC_SAT_EN
        o = 1'b0;
        if (s > MAXV) begin
            s = MAXV; o = 1'b1;
        end else if (s < MINV) begin
            s = MINV; o = 1'b1;
        end
        d = s[ACC_W-1:0];
`else
        d = s[ACC_W-1:0];
        o = 1'b0;
`endif
        sb_data.push_back(d);
        sb_ovf.push_back(o);
        terms.delete();
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the
    // model with the same inputs.
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d,
                                 input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        if (f) begin
            if (model_hold && !r && sb_data.size() > 0) begin
                void'(sb_data.pop_front());
                void'(sb_ovf.pop_front());
            end
            model_hold = 1'b0;
            terms.delete();
        end else if (model_hold) begin
            if (r) model_hold = 1'b0;
        end else if (v) begin
            terms.push_back(longint'($signed(d)));
            if (terms.size() == NTAPS) begin
                modelGroup();
                model_hold = 1'b1;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse between clock edges. Outputs must respond
    // before any edge arrives.
    task automatic pulseReset(input string tag);
        #1 rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_rst_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_rst_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_rst_out_ovf"}, 32'(out_ovf), 32'd0);
        rst = 1'b0;
        terms.delete();
        sb_data.delete();
        sb_ovf.delete();
        model_hold = 1'b0;
    endtask

    // Monitor: checks the handshake flags against the model on every
    // falling edge. It compares any presented result with the scoreboard
    // head and consumes the head when the sink takes it.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checkOutput("in_ready", 32'(in_ready), 32'(!model_hold));
            checkOutput("out_valid", 32'(out_valid), 32'(model_hold));
            if (out_valid) begin
                if (sb_data.size() == 0) begin
                    checkOutput("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("out_data", 32'(out_data), 32'(sb_data[0]));
                    checkOutput("out_ovf", 32'(out_ovf), 32'(sb_ovf[0]));
                    if (out_ready) begin
                        last_data = out_data;
                        last_ovf  = out_ovf;
                        void'(sb_data.pop_front());
                        void'(sb_ovf.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic [ACC_W-1:0]  exp_ovf_data;
        logic              exp_ovf_flag;

        rst = 1'b1;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset mid-group, then reset while a result is held.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
        pulseReset("midgroup");
        for (int i = 0; i < NTAPS; i++) applyStimulus(1'b1, 16'd50, 1'b0, 1'b0);
        checkOutput("hold_before_reset", 32'(out_valid), 32'd1);
        pulseReset("hold");

        // Basic sum, back-to-back with out_ready high.
        for (int i = 0; i < NTAPS; i++)
            applyStimulus(1'b1, (i % 2 == 0) ? 16'd432 : 16'd765, 1'b1, 1'b0);
        idle(3);
        checkOutput("basic_sum", 32'(last_data), 32'd4788);

        // Negative sum with in_valid gaps.
        for (int i = 0; i < 2 * NTAPS; i++)
            applyStimulus(i % 2 == 0, 16'hFFFF, 1'b1, 1'b0);
        idle(3);
        checkOutput("neg_sum", 32'(last_data), 32'h000FFFF8);
        checkOutput("neg_ovf", 32'(last_ovf), 32'd0);

        // Overflow group.
        for (int i = 0; i < NTAPS; i++) applyStimulus(1'b1, 16'd32767, 1'b1, 1'b0);
        idle(3);
`ifdef ACC_SAT_EN
        exp_ovf_data = 20'd32767;
        exp_ovf_flag = 1'b1;
`else
        exp_ovf_data = 20'h3FFF8;
        exp_ovf_flag = 1'b0;
`endif
        checkOutput("ovf_sum", 32'(last_data), 32'(exp_ovf_data));
        checkOutput("ovf_flag", 32'(last_ovf), 32'(exp_ovf_flag));

        // Backpressure: three stalled cycles, handshake on the fourth.
        // in_valid stays high throughout, so no term may leak in.
        for (int i = 0; i < NTAPS; i++) applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
            checkOutput("bp_out_data", 32'(out_data), 32'd40);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
        checkOutput("bp_in_ready_after", 32'(in_ready), 32'd1);
        idle(1);
        checkOutput("bp_sum", 32'(last_data), 32'd40);

        // Flush mid-group; the term presented with flush is discarded.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd1000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd999, 1'b1, 1'b1);
        for (int i = 0; i < NTAPS; i++) applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
        idle(3);
        checkOutput("flush_sum", 32'(last_data), 32'd16);

        // Randomized traffic with occasional flushes and extreme values.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: rd = 16'h7FFF;
                1: rd = 16'h8000;
                default: rd = 16'($urandom);
            endcase
            applyStimulus($urandom_range(0, 9) < 7, rd,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 49) == 0);
        end
        idle(4);
        checkOutput("scoreboard_empty", 32'(sb_data.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_tap_accumulator.md
# fir_tap_accumulator

Sequential multiply-accumulate back end for the FIR datapath: consumes one signed partial product per accepted beat, sums `NTAPS` of them in a widened accumulator, and presents one filter output sample per group. It sits directly downstream of the tap multipliers, in the position the stand-alone 16-bit carry-lookahead adder occupies in combinational form. Valid/ready handshakes are used on both sides so that it can stall against the output sink.

## Interface
- `DATA_W`, 16: width of the signed input partial product.
- `ACC_W`, 20: accumulator and output width. Must satisfy `ACC_W >= DATA_W + clog2(NTAPS)`.
- `NTAPS`, 8: number of terms per output sample (≥2).
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort of the current group.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a term this cycle.
- `in_data`  in  DATA_W  signed two's-complement partial product.
- `out_valid`  out  1  `out_data` holds a completed sum.
- `out_ready`  in  1  sink accepts the result.
- `out_data`  out  ACC_W  signed result.
- `out_ovf`  out  1  result was clamped (see Configuration).

## Operation
- The FSM has two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept occurs when `in_valid & in_ready`. On accept:
  - `in_data` is sign-extended to ACC_W and added to `acc`, modulo 2^ACC_W.
  - `cnt` increments.
- On the accept with `cnt == NTAPS-1`:
  - `acc + term` is registered into `out_data`.
  - `acc` is cleared to 0 and `cnt` to 0.
  - The state moves to HOLD.
- HOLD: `out_data` and `out_ovf` are held stable while `out_valid & !out_ready`. On `out_ready`=1 the state returns to ACCUM.
- `flush`=1 has the highest priority below reset:
  - Next state is ACCUM; `acc`, `cnt`, `out_valid` and `out_ovf` are cleared.
  - Any input term presented in that cycle is discarded, even though `in_ready` may be 1.
- Terms are never dropped or double-counted under `in_valid` gaps. `cnt` advances only on accept.

## Timing
- Reset values: state=ACCUM, `acc`=0, `cnt`=0, `out_data`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` or `in_valid` to any output.
- Latency: `out_valid` rises in the cycle after the NTAPS-th accept.
- Throughput: at most one group per NTAPS+1 cycles. HOLD lasts at least one cycle.
- The handshake completes on the edge where `out_valid & out_ready`. `in_ready` is 1 in the following cycle.
- `rst` asserted mid-group or in HOLD: all outputs take their reset values immediately, without waiting for a clock. The partial sum is lost.
- `flush` and a handshake in the same cycle: flush wins and the sink sees the transfer. The state is ACCUM either way.

## Configuration
- `ACC_SAT_EN` defined:
  - The result is clamped to the signed DATA_W range [−2^(DATA_W−1), 2^(DATA_W−1)−1] and sign-extended to ACC_W.
  - `out_ovf`=1 when clamping occurred; it is registered alongside `out_data`.
- `ACC_SAT_EN` undefined:
  - `out_data` is the raw ACC_W sum.
  - `out_ovf` is tied to 0.

## Test plan
1. Reset behaviour, with `rst` pulsed high asynchronously between edges:
   - `out_valid`=0, `in_ready`=1 and `out_data`=0 immediately.
   - After release, the first group starts from `cnt`=0.
2. Basic sum, no saturation path:
   - Stimulus: eight terms 432,765,432,765,432,765,432,765 back-to-back, with `out_ready`=1.
   - Expected: `out_data`=4788 and `out_valid` for exactly one cycle, one cycle after the 8th accept.
3. Negative sum with input gaps:
   - Stimulus: eight terms of −1 with `in_valid` toggling every other cycle.
   - Expected: `out_data`=20'hFFFF8 (−8), `out_ovf`=0.
4. Overflow:
   - Stimulus: eight terms of 32767.
   - Expected with `ACC_SAT_EN`: `out_data`=32767, `out_ovf`=1.
   - Expected without it: `out_data`=20'h3FFF8 (262136), `out_ovf`=0.
5. Backpressure:
   - Stimulus: complete a group with `out_ready`=0 for 3 cycles.
   - Expected: `out_data` stable and `in_ready`=0 throughout. The handshake completes on the 4th cycle, and `in_ready`=1 on the next cycle.
6. Flush mid-group:
   - Stimulus: 3 terms of 1000, then `flush` for one cycle, then eight terms of 2.
   - Expected: `out_data`=16, and there is no output for the aborted group.
